// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: command kinds, opcodes
// and the signed immediate limits each encoding format can hold.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        ENC_LOAD   = 3'd0,
        ENC_STORE  = 3'd1,
        ENC_ALU_R  = 3'd2,
        ENC_ALU_I  = 3'd3,
        ENC_BRANCH = 3'd4,
        ENC_JAL    = 3'd5,
        ENC_LUI    = 3'd6,
        ENC_LI     = 3'd7
    } enc_kind_t;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_ALU_R  = 7'b0110011,
        OP_ALU_I  = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_LUI    = 7'b0110111
    } opcode_t;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int BIMM_MIN  = -4096;
    localparam int BIMM_MAX  = 4094;
    localparam int JIMM_MIN  = -1048576;
    localparam int JIMM_MAX  = 1048574;

    function automatic logic in_range(input logic [31:0] value, input int lo, input int hi);
        return ($signed(value) >= lo) && ($signed(value) <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_packer.sv
// Combinational RV32I word packer: builds the first (or only) word for a
// command, the trailing ADDI for a two-word LI, and flags out-of-range immediates.
module instr_packer
    import instr_encoder_pkg::*;
(
    input  enc_kind_t   kind_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic [31:0] lo_word_o,
    output logic        two_word_o,
    output logic        err_o
);

    logic        is_shift;
    logic [19:0] li_hi;

    // Rounding the upper part up by imm[11] compensates for the sign-extended low ADDI.
    assign li_hi    = imm_i[31:12] + {19'd0, imm_i[11]};
    assign is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);

    always_comb begin
        word_o     = '0;
        lo_word_o  = '0;
        two_word_o = 1'b0;
        err_o      = 1'b0;
        unique case (kind_i)
            ENC_LOAD: begin
                word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
                err_o  = !in_range(imm_i, IMM12_MIN, IMM12_MAX);
            end
            ENC_STORE: begin
                word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
                err_o  = !in_range(imm_i, IMM12_MIN, IMM12_MAX);
            end
            ENC_ALU_R: begin
                word_o = {1'b0, funct7b5_i, 5'd0, rs2_i, rs1_i, funct3_i, rd_i, OP_ALU_R};
            end
            ENC_ALU_I: begin
                if (is_shift) begin
                    word_o = {1'b0, funct7b5_i, 5'd0, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_ALU_I};
                    err_o  = (imm_i > 32'd31);
                end else begin
                    word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_ALU_I};
                    err_o  = !in_range(imm_i, IMM12_MIN, IMM12_MAX);
                end
            end
            ENC_BRANCH: begin
                word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], OP_BRANCH};
                err_o  = !in_range(imm_i, BIMM_MIN, BIMM_MAX) || imm_i[0];
            end
            ENC_JAL: begin
                word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
                err_o  = !in_range(imm_i, JIMM_MIN, JIMM_MAX) || imm_i[0];
            end
            ENC_LUI: begin
                word_o = {imm_i[31:12], rd_i, OP_LUI};
                err_o  = (imm_i[11:0] != 12'd0);
            end
            ENC_LI: begin
                if (in_range(imm_i, IMM12_MIN, IMM12_MAX)) begin
                    word_o = {imm_i[11:0], 5'd0, 3'b000, rd_i, OP_ALU_I};
                end else begin
                    two_word_o = 1'b1;
                    word_o     = {li_hi, rd_i, OP_LUI};
                    lo_word_o  = {imm_i[11:0], rd_i, 3'b000, rd_i, OP_ALU_I};
                end
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder: accepts commands, writes packed words to consecutive
// instruction-memory addresses, and splits large LI values into LUI+ADDI.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  enc_kind_t             cmd_kind_i,
    input  logic [4:0]            cmd_rd_i,
    input  logic [4:0]            cmd_rs1_i,
    input  logic [4:0]            cmd_rs2_i,
    input  logic [2:0]            cmd_funct3_i,
    input  logic                  cmd_funct7b5_i,
    input  logic [31:0]           cmd_imm_i,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {IDLE, RUN, LI_LO} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LAST_C  = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  err_q, err_d;
    logic [31:0]           pend_q, pend_d;

    logic [31:0] pk_word, pk_lo_word;
    logic        pk_two_word, pk_err;
    logic        accept;

    instr_packer u_packer (
        .kind_i     (cmd_kind_i),
        .rd_i       (cmd_rd_i),
        .rs1_i      (cmd_rs1_i),
        .rs2_i      (cmd_rs2_i),
        .funct3_i   (cmd_funct3_i),
        .funct7b5_i (cmd_funct7b5_i),
        .imm_i      (cmd_imm_i),
        .word_o     (pk_word),
        .lo_word_o  (pk_lo_word),
        .two_word_o (pk_two_word),
        .err_o      (pk_err)
    );

    assign full_o      = (count_q == DEPTH_C);
    assign cmd_ready_o = !rst_i && !clear_i && !full_o && (state_q != LI_LO);
    assign accept      = cmd_valid_i && cmd_ready_o;

    // A two-word LI needs two free words; with only one left it is rejected whole.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        pend_d  = pend_q;
        if (clear_i) begin
            state_d = IDLE;
            count_d = '0;
            err_d   = 1'b0;
        end else if (state_q == LI_LO) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_WIDTH-1:0];
            wdata_d = pend_q;
            count_d = count_q + 1'b1;
            state_d = RUN;
        end else if (accept) begin
            state_d = RUN;
            if (pk_err || (pk_two_word && count_q == LAST_C)) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_WIDTH-1:0];
                wdata_d = pk_word;
                count_d = count_q + 1'b1;
                if (pk_two_word) begin
                    pend_d  = pk_lo_word;
                    state_d = LI_LO;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign count_o      = count_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-depth instance for encodings and
// errors, and a 4-word instance for fill, saturation and LI-at-boundary cases.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clearB, clearS;
    logic        validB, validS;
    enc_kind_t   kind;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;

    logic        readyB, weB, fullB, errB;
    logic [9:0]  addrB;
    logic [31:0] wdataB;
    logic [10:0] countB;

    logic        readyS, weS, fullS, errS;
    logic [1:0]  addrS;
    logic [31:0] wdataS;
    logic [2:0]  countS;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_WIDTH(10)) dutBig (
        .clk_i(clk), .rst_i(rst), .clear_i(clearB),
        .cmd_valid_i(validB), .cmd_ready_o(readyB), .cmd_kind_i(kind),
        .cmd_rd_i(rd), .cmd_rs1_i(rs1), .cmd_rs2_i(rs2),
        .cmd_funct3_i(f3), .cmd_funct7b5_i(f7b5), .cmd_imm_i(imm),
        .imem_we_o(weB), .imem_addr_o(addrB), .imem_wdata_o(wdataB),
        .count_o(countB), .full_o(fullB), .err_o(errB)
    );

    instr_encoder #(.ADDR_WIDTH(2)) dutSmall (
        .clk_i(clk), .rst_i(rst), .clear_i(clearS),
        .cmd_valid_i(validS), .cmd_ready_o(readyS), .cmd_kind_i(kind),
        .cmd_rd_i(rd), .cmd_rs1_i(rs1), .cmd_rs2_i(rs2),
        .cmd_funct3_i(f3), .cmd_funct7b5_i(f7b5), .cmd_imm_i(imm),
        .imem_we_o(weS), .imem_addr_o(addrS), .imem_wdata_o(wdataS),
        .count_o(countS), .full_o(fullS), .err_o(errS)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input enc_kind_t k, input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [2:0] fn3, input logic fn7,
                                 input logic [31:0] im);
        kind = k; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7b5 = fn7; imm = im;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; clearB = 1'b0; clearS = 1'b0; validB = 1'b0; validS = 1'b0;
        applyStimulus(ENC_ALU_I, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
        tick(); tick();
        checkOutput("rst_ready", {31'd0, readyB}, 32'd0);
        checkOutput("rst_we", {31'd0, weB}, 32'd0);
        checkOutput("rst_count", {21'd0, countB}, 32'd0);
        checkOutput("rst_err_full", {30'd0, errB, fullB}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", {31'd0, readyB}, 32'd1);

        // ADDI x5, x0, 42
        applyStimulus(ENC_ALU_I, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'd42);
        validB = 1'b1;
        tick(); validB = 1'b0;
        checkOutput("addi_we", {31'd0, weB}, 32'd1);
        checkOutput("addi_addr", {22'd0, addrB}, 32'd0);
        checkOutput("addi_wdata", wdataB, 32'h02A00293);
        checkOutput("addi_count", {21'd0, countB}, 32'd1);
        tick();
        checkOutput("idle_we", {31'd0, weB}, 32'd0);

        // Two-word LI x1, 0x12345FFF
        applyStimulus(ENC_LI, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF);
        validB = 1'b1;
        tick(); validB = 1'b0;
        checkOutput("li_lui_addr", {22'd0, addrB}, 32'd1);
        checkOutput("li_lui_wdata", wdataB, 32'h123460B7);
        checkOutput("li_ready_low", {31'd0, readyB}, 32'd0);
        tick();
        checkOutput("li_addi_we", {31'd0, weB}, 32'd1);
        checkOutput("li_addi_addr", {22'd0, addrB}, 32'd2);
        checkOutput("li_addi_wdata", wdataB, 32'hFFF08093);
        checkOutput("li_count", {21'd0, countB}, 32'd3);
        checkOutput("li_ready_back", {31'd0, readyB}, 32'd1);

        // Back-to-back BRANCH then STORE
        applyStimulus(ENC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd8);
        validB = 1'b1;
        tick();
        checkOutput("branch_wdata", wdataB, 32'hFE208CE3);
        checkOutput("branch_addr", {22'd0, addrB}, 32'd3);
        applyStimulus(ENC_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd12);
        tick(); validB = 1'b0;
        checkOutput("store_wdata", wdataB, 32'h0020A623);
        checkOutput("store_count", {21'd0, countB}, 32'd5);

        // LOAD, LUI, SUB, SRAI, short LI
        validB = 1'b1;
        applyStimulus(ENC_LOAD, 5'd6, 5'd2, 5'd0, 3'b010, 1'b0, -32'sd4);
        tick();
        checkOutput("load_wdata", wdataB, 32'hFFC12303);
        applyStimulus(ENC_LUI, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000);
        tick();
        checkOutput("lui_wdata", wdataB, 32'h12345137);
        applyStimulus(ENC_ALU_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'hDEADBEEF);
        tick();
        checkOutput("sub_wdata", wdataB, 32'h402081B3);
        applyStimulus(ENC_ALU_I, 5'd1, 5'd1, 5'd0, 3'b101, 1'b1, 32'd3);
        tick();
        checkOutput("srai_wdata", wdataB, 32'h4030D093);
        applyStimulus(ENC_LI, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, -32'sd5);
        tick(); validB = 1'b0;
        checkOutput("li_short_wdata", wdataB, 32'hFFB00093);
        checkOutput("li_short_count", {21'd0, countB}, 32'd10);
        checkOutput("li_short_ready", {31'd0, readyB}, 32'd1);

        // Range errors: odd JAL offset, oversize shift, out-of-range ADDI
        applyStimulus(ENC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3);
        validB = 1'b1;
        tick(); validB = 1'b0;
        checkOutput("jal_err", {31'd0, errB}, 32'd1);
        checkOutput("jal_we", {31'd0, weB}, 32'd0);
        checkOutput("jal_count", {21'd0, countB}, 32'd10);
        tick();
        checkOutput("err_sticky", {31'd0, errB}, 32'd1);
        clearB = 1'b1;
        tick(); clearB = 1'b0;
        checkOutput("clear_err", {31'd0, errB}, 32'd0);
        checkOutput("clear_count", {21'd0, countB}, 32'd0);
        applyStimulus(ENC_ALU_I, 5'd1, 5'd1, 5'd0, 3'b001, 1'b0, 32'd32);
        validB = 1'b1;
        tick(); validB = 1'b0;
        checkOutput("shift_err", {30'd0, errB, weB}, 32'd2);
        clearB = 1'b1;
        tick(); clearB = 1'b0;
        applyStimulus(ENC_ALU_I, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
        validB = 1'b1;
        tick(); validB = 1'b0;
        checkOutput("addi_range_err", {30'd0, errB, weB}, 32'd2);
        applyStimulus(ENC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd4094);
        clearB = 1'b1;
        tick(); clearB = 1'b0;
        validB = 1'b1;
        tick(); validB = 1'b0;
        checkOutput("branch_max_ok", {30'd0, errB, weB}, 32'd1);
        checkOutput("branch_max_wdata", wdataB, 32'h7E208FE3);

        // Small instance: fill to saturation
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ENC_ALU_I, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, i);
            validS = 1'b1;
            tick();
            checkOutput($sformatf("fill_addr%0d", i), {30'd0, addrS}, i);
            checkOutput($sformatf("fill_wdata%0d", i), wdataS, 32'h00000093 | (i << 20));
        end
        checkOutput("fill_full", {31'd0, fullS}, 32'd1);
        checkOutput("fill_ready", {31'd0, readyS}, 32'd0);
        checkOutput("fill_count", {29'd0, countS}, 32'd4);
        tick(); validS = 1'b0;
        checkOutput("held_we", {31'd0, weS}, 32'd0);
        checkOutput("held_count", {29'd0, countS}, 32'd4);
        clearS = 1'b1;
        tick(); clearS = 1'b0;
        checkOutput("small_clear", {28'd0, countS, fullS}, 32'd0);

        // Three ADDIs then a two-word LI with one free word
        validS = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(ENC_ALU_I, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7);
            tick();
        end
        applyStimulus(ENC_LI, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF);
        tick(); validS = 1'b0;
        checkOutput("li_nofit_err", {31'd0, errS}, 32'd1);
        checkOutput("li_nofit_we", {31'd0, weS}, 32'd0);
        checkOutput("li_nofit_count", {29'd0, countS}, 32'd3);

        // Clear while the ADDI half is pending
        clearS = 1'b1;
        tick(); clearS = 1'b0;
        validS = 1'b1;
        tick(); validS = 1'b0;
        checkOutput("lilo_lui_we", {31'd0, weS}, 32'd1);
        checkOutput("lilo_lui_wdata", wdataS, 32'h123460B7);
        clearS = 1'b1;
        tick();
        checkOutput("lilo_discard_we", {31'd0, weS}, 32'd0);
        checkOutput("lilo_discard_count", {29'd0, countS}, 32'd0);
        checkOutput("lilo_ready_in_clear", {31'd0, readyS}, 32'd0);
        clearS = 1'b0;
        #1;
        checkOutput("lilo_ready_after", {31'd0, readyS}, 32'd1);
        tick();
        checkOutput("lilo_no_late_write", {31'd0, weS}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and instruction-memory writer, the inverse of the processor's opcode decoding path. It accepts abstract instruction commands over a valid/ready handshake, packs them into 32-bit RV32I words, and writes them to consecutive instruction-memory words. The `ENC_LI` pseudo-instruction is expanded to LUI+ADDI when required. The block sits between the host/loader command stream and the instruction-memory write port, and runs while the core is held in reset.

## Interface
- `ADDR_WIDTH`, 10: instruction-memory word-address width; DEPTH = 2^ADDR_WIDTH.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock; reset is synchronous and active-high.
- `clear_i` in 1: synchronous restart. Pointer, count and error return to 0; state returns to IDLE.
- `cmd_valid_i` in 1: command valid.
- `cmd_ready_o` out 1: command ready.
- `cmd_kind_i` in `enc_kind_t` (3): ENC_LOAD, ENC_STORE, ENC_ALU_R, ENC_ALU_I, ENC_BRANCH, ENC_JAL, ENC_LUI, ENC_LI.
- `cmd_rd_i`, `cmd_rs1_i`, `cmd_rs2_i` in 5 each: register indices.
- `cmd_funct3_i` in 3; `cmd_funct7b5_i` in 1: function fields.
- `cmd_imm_i` in 32: signed immediate or byte offset. For LUI/LI it is the full 32-bit value.
- `imem_we_o` out 1; `imem_addr_o` out ADDR_WIDTH; `imem_wdata_o` out 32: registered write port.
- `count_o` out ADDR_WIDTH+1: words written since reset/clear.
- `full_o` out 1: count_o == DEPTH.
- `err_o` out 1: sticky error flag.

## Operation
- Accept = `cmd_valid_i && cmd_ready_o`.
- `cmd_ready_o` = !rst_i && !clear_i && !full_o && state != LI_LO.
- Opcodes: LOAD 0000011, STORE 0100011, ALU_R 0110011, ALU_I 0010011, BRANCH 1100011, JAL 1101111, LUI 0110111.
- Immediate formats: LOAD and ALU_I use I; STORE uses S; BRANCH uses B; JAL uses J; LUI uses U.
- Range checks. Any failing command is consumed, writes nothing, and sets `err_o`.
  - I/S: -2048..2047.
  - B: -4096..4094, bit0 = 0.
  - J: ±1 MiB, bit0 = 0.
  - LUI: imm[11:0] = 0.
  - ALU_I with funct3 001/101 (shifts): imm 0..31; bit30 = funct7b5.
- `ENC_ALU_R`: bit30 = funct7b5; imm ignored.
- `ENC_LI`:
  - If imm fits -2048..2047: emits a single `ADDI rd,x0,imm`.
  - Otherwise: emits LUI rd,hi then `ADDI rd,rd,lo`, where lo = imm[11:0] (sign-extended) and hi = (imm + 0x800)[31:12] (mod 2^32).
  - If a two-word LI is accepted with only one free word left: no write, `err_o` set.
- FSM:
  - IDLE/RUN: normal operation.
  - LI_LO: pending ADDI half. Entered on accept of a two-word LI. Returns to RUN after one cycle.
- Write pointer = count_o[ADDR_WIDTH-1:0]. It increments per word written and saturates at DEPTH, where `full_o` holds and `cmd_ready_o` stays low.
- `err_o` clears only on rst_i/clear_i.

## Timing
- Reset values: `cmd_ready_o` 0 during reset, then 1 the first cycle after. All other outputs 0.
- Single-word command accepted in cycle N: `imem_we_o`=1 in N+1 with addr = old pointer. Throughput 1 word/cycle.
- Two-word LI accepted in N:
  - LUI written in N+1 (ready low in N+1).
  - ADDI written in N+2 at addr+1.
  - The next command can be accepted in N+2.
- Error detected in N: `err_o`=1 from N+1; `imem_we_o` stays 0.
- `clear_i` wins over accept. Asserted in LI_LO, it discards the ADDI half (no write). Count becomes 0 the next cycle.
- `full_o` rises the cycle the DEPTH-th word is written.

## Structure
- Shared package gains:
  - `enc_kind_t`.
  - Opcode constants, reusing the existing `opcode_t` values.
  - Immediate-range limit constants.
- Sub-module `instr_packer`, combinational: kind/fields/imm in, word + range error out. It also serves the LI lo/hi split.
- The top holds the FSM, pointer, count, and output registers.

## Test plan
- ALU_I rd=5 rs1=0 f3=0 imm=42 -> next cycle we=1, addr=0, wdata=0x02A00293, count=1.
- LI rd=1 imm=0x12345FFF -> addr0 0x123460B7, addr1 0xFFF08093, ready low in between, count=2.
- BRANCH rs1=1 rs2=2 f3=0 imm=-8 -> 0xFE208CE3; STORE rs1=1 rs2=2 f3=010 imm=12 -> 0x0020A623.
- JAL rd=1 imm=3 -> no write, err_o=1 next cycle, count unchanged; clear_i -> err_o=0, count=0.
- ADDR_WIDTH=2:
  - Four back-to-back ADDIs -> addrs 0..3, full_o=1, ready low, fifth command held.
  - After clear_i, three ADDIs then two-word LI -> err_o=1, count=3.
- clear_i during LI_LO -> ADDI half not written, count=0 next cycle, ready=1 after clear_i drops.
